adder_pipe_top: RTL and testbench

- Parametrised successor to the fixed-width registered adder benchmark.
- Computes a+b or a-b over WIDTH bits. The carry chain is split into STAGES pipelined segments, so the critical path scales with WIDTH/STAGES.
- Uses a valid/ready handshake with a global stall.
- Serves as an arithmetic benchmark block for width and pipeline-depth sweeps.

---
 rtl/adder_pipe_top.sv | 127 ++++++++++++
 tb/tb_adder_pipe_top.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_top.sv
// adder_pipe_top
//   Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
//   segments of SEG = ceil(WIDTH/STAGES) bits. Each stage adds one segment with
//   the carry registered by the stage before it. Operand bits that are still
//   needed and sum bits that are already done travel along in skew registers.
//   One global enable (adv) moves the whole pipeline forward, so a stalled
//   output freezes every stage.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    operand beat handshake (in_ready = adv)
//   a, b, op, cin          operands; op=1 computes a-b (cin is ignored)
//   out_valid / out_ready  result handshake
//   sum[WIDTH:0]           result; MSB is carry-out, or no-borrow in subtract
//   beat_count[31:0]       results consumed, wraps at 2^32
module adder_pipe_top #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [31:0]      beat_count
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    // Operands are only needed up to the last adding stage, so stage STAGES has
    // no operand skew registers. r_s[0] is the (empty) partial sum entering
    // stage 1 and stays zero.
    logic [WIDTH-1:0] r_a [0:STAGES-1];
    logic [WIDTH-1:0] r_b [0:STAGES-1];
    logic [WIDTH-1:0] r_s [0:STAGES];
    logic [STAGES:0]  r_c;
    logic [STAGES:0]  r_vld_pipe;
    logic [31:0]      r_beat;

    logic [WIDTH-1:0] w_s_nxt [1:STAGES];
    logic [STAGES:1]  w_c_nxt;
    logic             w_adv;

    // Adds segment k-1 of fa+fb+fc and merges it into partial sum fs.
    // Masked operands are below 2^hi and the carry-in sits at 2^lo, so the
    // segment's carry-out lands exactly on bit hi of the WIDTH+1 result.
    // An empty segment (lo >= WIDTH) passes sum and carry through.
    function automatic logic [WIDTH:0] seg_add(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb,
        input logic [WIDTH-1:0] fs,
        input logic             fc,
        input int               k
    );
        logic [WIDTH:0] one;
        logic [WIDTH:0] m;
        logic [WIDTH:0] t;
        int             lo;
        int             hi;
        lo  = (k - 1) * SEG;
        hi  = (k * SEG > WIDTH) ? WIDTH : k * SEG;
        one = {{WIDTH{1'b0}}, 1'b1};
        if (lo >= WIDTH) begin
            seg_add = {fc, fs};
        end else begin
            m = (one << hi) - (one << lo);
            t = ({1'b0, fa} & m) + ({1'b0, fb} & m) + ({{WIDTH{1'b0}}, fc} << lo);
            seg_add = {t[hi], (fs & ~m[WIDTH-1:0]) | (t[WIDTH-1:0] & m[WIDTH-1:0])};
        end
    endfunction

    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            {w_c_nxt[k], w_s_nxt[k]} = seg_add(r_a[k-1], r_b[k-1], r_s[k-1], r_c[k-1], k);
        end
    end

    assign w_adv      = !r_vld_pipe[STAGES] | out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_vld_pipe[STAGES];
    assign sum        = {r_c[STAGES], r_s[STAGES]};
    assign beat_count = r_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_c        <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            // Bubbles still load data; only the valid bit marks the slot empty.
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
            r_a[0]     <= a;
            r_b[0]     <= op ? ~b : b;
            r_c[0]     <= op | cin;
            r_s[0]     <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            for (int k = 1; k <= STAGES; k++) begin
                r_s[k] <= w_s_nxt[k];
                r_c[k] <= w_c_nxt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (out_valid && out_ready) begin
            r_beat <= r_beat + 32'd1;
        end
    end

endmodule

// File: tb/tb_adder_pipe_top.sv
module tb_adder_pipe_top;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         cin;
    logic         out_ready;

    logic         rdy3, ov3, rdy1, ov1, rdy6, ov6;
    logic [W:0]   s3, s1, s6;
    logic [31:0]  bc3, bc1, bc6;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // expected results / accept cycles, observed results / fire cycles
    logic [W:0] e3_q[$], o3_q[$], e1_q[$], o1_q[$], e6_q[$], o6_q[$];
    int         a3_q[$], c3_q[$], a1_q[$], c1_q[$], a6_q[$], c6_q[$];

    adder_pipe_top #(.WIDTH(W), .STAGES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov3), .out_ready(out_ready),
        .sum(s3), .beat_count(bc3));

    adder_pipe_top #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov1), .out_ready(out_ready),
        .sum(s1), .beat_count(bc1));

    adder_pipe_top #(.WIDTH(W), .STAGES(W)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov6), .out_ready(out_ready),
        .sum(s6), .beat_count(bc6));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: add = a+b+cin; subtract = a-b offset by 2^W so bit W is the
    // no-borrow flag.
    function automatic logic [W:0] model(input int fa, input int fb, input bit fop, input bit fcin);
        int r;
        if (fop) r = fa - fb + (1 << W);
        else     r = fa + fb + int'(fcin);
        return r[W:0];
    endfunction

    // Handshake recorder: sampled mid-cycle, each entry is a transfer that the
    // following rising edge performs.
    always @(negedge clk) begin
        if (!rst_n) begin
            e3_q.delete(); o3_q.delete(); a3_q.delete(); c3_q.delete();
            e1_q.delete(); o1_q.delete(); a1_q.delete(); c1_q.delete();
            e6_q.delete(); o6_q.delete(); a6_q.delete(); c6_q.delete();
        end else begin
            if (in_valid && rdy3) begin e3_q.push_back(model(a, b, op, cin)); a3_q.push_back(cyc); end
            if (in_valid && rdy1) begin e1_q.push_back(model(a, b, op, cin)); a1_q.push_back(cyc); end
            if (in_valid && rdy6) begin e6_q.push_back(model(a, b, op, cin)); a6_q.push_back(cyc); end
            if (ov3 && out_ready) begin o3_q.push_back(s3); c3_q.push_back(cyc); end
            if (ov1 && out_ready) begin o1_q.push_back(s1); c1_q.push_back(cyc); end
            if (ov6 && out_ready) begin o6_q.push_back(s6); c6_q.push_back(cyc); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_rand();
        a   = W'($urandom_range(0, (1 << W) - 1));
        b   = W'($urandom_range(0, (1 << W) - 1));
        op  = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    // Sends one beat into an empty pipeline and waits (bounded) for the
    // result on the STAGES=3 instance. lat = -1 on timeout.
    task automatic run_one(input int fa, input int fb, input bit fop, input bit fcin,
                           output logic [W:0] res, output int lat);
        a = W'(fa); b = W'(fb); op = fop; cin = fcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!ov3 && lat < 20) begin
            tick();
            lat++;
        end
        res = s3;
        if (!ov3) lat = -1;
        tick();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0; cin = 1'b0;
        rst_n = 1'b0;
        #13;
        n_chk++; if (ov3 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov3); else n_pass++;
        n_chk++; if (s3 !== '0) $display("FAIL reset_sum: got %h want 0", s3); else n_pass++;
        n_chk++; if (bc3 !== 32'd0) $display("FAIL reset_beat_count: got %0d want 0", bc3); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++; if (rdy3 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", rdy3); else n_pass++;
    endtask

    task automatic test_add_sub();
        logic [W:0] r;
        int lat;
        do_reset();
        run_one(63, 63, 1'b0, 1'b0, r, lat);
        n_chk++; if (lat !== 4) $display("FAIL add_max_latency: got %0d want 4", lat); else n_pass++;
        n_chk++; if (r !== 7'h7E) $display("FAIL add_max_sum: got %h want 7e", r); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            run_one(5, 9, 1'b1, c[0], r, lat);
            n_chk++; if (r !== 7'h3C) $display("FAIL sub_5_9 cin=%0d: got %h want 3c", c, r); else n_pass++;
            run_one(9, 5, 1'b1, c[0], r, lat);
            n_chk++; if (r !== 7'h44) $display("FAIL sub_9_5 cin=%0d: got %h want 44", c, r); else n_pass++;
        end
        run_one(7, 7, 1'b1, 1'b0, r, lat);
        n_chk++; if (r !== 7'h40) $display("FAIL sub_equal: got %h want 40", r); else n_pass++;
        run_one(0, 0, 1'b0, 1'b1, r, lat);
        n_chk++; if (r !== 7'h01) $display("FAIL add_cin_only: got %h want 01", r); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a = W'(i); b = W'(2 * i); op = 1'b0; cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_chk++; if (o3_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", o3_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < o3_q.size(); i++) begin
            n_chk++; if (o3_q[i] !== 7'(3 * i)) $display("FAIL b2b_sum[%0d]: got %0d want %0d", i, o3_q[i], 3 * i); else n_pass++;
            n_chk++; if (c3_q[i] != c3_q[0] + i) $display("FAIL b2b_consecutive[%0d]: got %0d want %0d", i, c3_q[i], c3_q[0] + i); else n_pass++;
        end
        n_chk++; if (bc3 !== 32'd8) $display("FAIL b2b_beat_count: got %0d want 8", bc3); else n_pass++;
    endtask

    task automatic test_stall();
        logic [W:0] snap;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_rand(); in_valid = 1'b1;
            tick();
        end
        drive_rand();
        out_ready = 1'b0;
        n_chk++; if (ov3 !== 1'b1) $display("FAIL stall_pending: got %b want 1", ov3); else n_pass++;
        snap = s3;
        for (int j = 0; j < 5; j++) begin
            tick();
            drive_rand();
            n_chk++; if (rdy3 !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", j, rdy3); else n_pass++;
            n_chk++; if (ov3 !== 1'b1) $display("FAIL stall_out_valid[%0d]: got %b want 1", j, ov3); else n_pass++;
            n_chk++; if (s3 !== snap) $display("FAIL stall_sum[%0d]: got %h want %h", j, s3, snap); else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_rand();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        n_chk++; if (e3_q.size() != 12) $display("FAIL stall_accepted: got %0d want 12", e3_q.size()); else n_pass++;
        n_chk++; if (o3_q.size() != e3_q.size()) $display("FAIL stall_emitted: got %0d want %0d", o3_q.size(), e3_q.size()); else n_pass++;
        for (int i = 0; i < e3_q.size() && i < o3_q.size(); i++) begin
            n_chk++; if (o3_q[i] !== e3_q[i]) $display("FAIL stall_order[%0d]: got %h want %h", i, o3_q[i], e3_q[i]); else n_pass++;
        end
        n_chk++; if (bc3 !== 32'd12) $display("FAIL stall_beat_count: got %0d want 12", bc3); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_rand(); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (bc3 !== 32'd1) $display("FAIL mid_pre_beat_count: got %0d want 1", bc3); else n_pass++;
        n_chk++; if (ov3 !== 1'b1) $display("FAIL mid_pre_out_valid: got %b want 1", ov3); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (ov3 !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", ov3); else n_pass++;
        n_chk++; if (s3 !== '0) $display("FAIL mid_sum: got %h want 0", s3); else n_pass++;
        n_chk++; if (bc3 !== 32'd0) $display("FAIL mid_beat_count: got %0d want 0", bc3); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov3 || ov1 || ov6) seen++;
        end
        n_chk++; if (seen != 0) $display("FAIL mid_stale_results: got %0d want 0", seen); else n_pass++;
        n_chk++; if (bc3 !== 32'd0) $display("FAIL mid_post_beat_count: got %0d want 0", bc3); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [W:0] eq[$], oq[$];
        int aq[$], cq[$];
        int lat_exp;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive_rand();
            in_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        for (int d = 0; d < 3; d++) begin
            case (d)
                0:       begin eq = e3_q; oq = o3_q; aq = a3_q; cq = c3_q; lat_exp = 4; end
                1:       begin eq = e1_q; oq = o1_q; aq = a1_q; cq = c1_q; lat_exp = 2; end
                default: begin eq = e6_q; oq = o6_q; aq = a6_q; cq = c6_q; lat_exp = 7; end
            endcase
            n_chk++; if (oq.size() != eq.size() || eq.size() == 0)
                $display("FAIL sweep_count lat%0d: got %0d want %0d", lat_exp, oq.size(), eq.size()); else n_pass++;
            for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
                n_chk++; if (oq[i] !== eq[i])
                    $display("FAIL sweep_sum lat%0d[%0d]: got %h want %h", lat_exp, i, oq[i], eq[i]); else n_pass++;
                n_chk++; if (cq[i] - aq[i] != lat_exp)
                    $display("FAIL sweep_latency lat%0d[%0d]: got %0d want %0d", lat_exp, i, cq[i] - aq[i], lat_exp); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
